// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one registered read port, write-first
// on same-address collisions, asynchronous active-high reset of the read register only.
module ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter     TAG        = "Ram"
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WIDTH-1:0]      dataIn,
    output logic [WIDTH-1:0]      dataOut
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage carries no reset so it maps onto block RAM; contents start undefined.
    reg [WIDTH-1:0] mem [0:DEPTH-1];

    logic             wr_en;
    logic             collide;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] data_out_d;
    logic [WIDTH-1:0] data_out_q;

    always_comb begin
        wr_en      = we && !res;
        collide    = we && (writeAddr == readAddr);
        rd_word    = mem[readAddr];
        data_out_d = data_out_q;
        if (re) begin
            // Bypass the array so a colliding read returns the word being written.
            data_out_d = collide ? dataIn : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[writeAddr] <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign dataOut = data_out_q;

`ifdef DEBUG_DISPLAY
    always_ff @(posedge clk) begin
        if (wr_en) begin
            $display("[%s] write %0h %0h", TAG, writeAddr, dataIn);
        end
    end
`endif

endmodule

// File: tb/tb_ram.sv
// Bench for ram: directed literal cases plus randomized traffic checked every
// cycle against an associative-array memory model.
module tb_ram;

    localparam int W  = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          re  = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] readAddr  = '0;
    logic [AW-1:0] writeAddr = '0;
    logic [W-1:0]  dataIn    = '0;
    logic [W-1:0]  dataOut;

    int checks = 0;
    int errors = 0;

    ram #(.WIDTH(W), .ADDR_WIDTH(AW), .TAG("TbRam")) dut (
        .clk      (clk),
        .res      (res),
        .re       (re),
        .we       (we),
        .readAddr (readAddr),
        .writeAddr(writeAddr),
        .dataIn   (dataIn),
        .dataOut  (dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory as a sparse map, expected output plus a
    // "known" flag (reads of never-written words are undefined).
    logic [W-1:0] model_mem [int];
    logic [W-1:0] exp_out   = '0;
    bit           exp_known = 1'b0;

    always @(posedge clk) begin
        if (res) begin
            exp_out   = '0;
            exp_known = 1'b1;
        end else begin
            if (re) begin
                if (we && writeAddr == readAddr) begin
                    exp_out   = dataIn;
                    exp_known = 1'b1;
                end else if (model_mem.exists(int'(readAddr))) begin
                    exp_out   = model_mem[int'(readAddr)];
                    exp_known = 1'b1;
                end else begin
                    exp_known = 1'b0;
                end
            end
            if (we) model_mem[int'(writeAddr)] = dataIn;
        end
    end

    always @(posedge res) begin
        exp_out   = '0;
        exp_known = 1'b1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (exp_known) check("model", dataOut, exp_out);
    end

    // Apply inputs, let one rising edge sample them, return 2ns after it.
    task automatic drive(input bit r, input bit w, input logic [AW-1:0] ra,
                         input logic [AW-1:0] wa, input logic [W-1:0] d);
        re = r; we = w; readAddr = ra; writeAddr = wa; dataIn = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk);
        #2;
        repeat (3) drive(1'b1, 1'b0, 12'h000, 12'h000, 32'h0);
        check("reset_state", dataOut, 32'h0);
        res = 1'b0;

        // Write then read on the following cycle.
        drive(1'b0, 1'b1, 12'h000, 12'h005, 32'h12345678);
        drive(1'b1, 1'b0, 12'h005, 12'h000, 32'h0);
        check("write_read", dataOut, 32'h12345678);

        // Output holds while re is low, even as the read word is overwritten.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 12'h005, 12'h005, 32'hAAAA0000);
            check("hold", dataOut, 32'h12345678);
        end
        drive(1'b1, 1'b0, 12'h005, 12'h000, 32'h0);
        check("hold_overwrite", dataOut, 32'hAAAA0000);

        drive(1'b1, 1'b1, 12'h0FF, 12'h0FF, 32'hCAFEF00D);
        check("collision", dataOut, 32'hCAFEF00D);

        drive(1'b0, 1'b1, 12'h000, 12'h001, 32'h00000011);
        drive(1'b1, 1'b1, 12'h001, 12'h002, 32'h00000022);
        check("parallel_old", dataOut, 32'h00000011);
        drive(1'b1, 1'b0, 12'h002, 12'h000, 32'h0);
        check("parallel_new", dataOut, 32'h00000022);

        drive(1'b0, 1'b1, 12'h000, 12'h000, 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 12'h000, 12'hFFF, 32'h00000001);
        drive(1'b1, 1'b0, 12'h000, 12'h000, 32'h0);
        check("extreme_low", dataOut, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 12'hFFF, 12'h000, 32'h0);
        check("extreme_high", dataOut, 32'h00000001);

        // Asynchronous reset mid-cycle, write under reset dropped.
        drive(1'b0, 1'b1, 12'h000, 12'h010, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 12'h010, 12'h000, 32'h0);
        check("pre_reset", dataOut, 32'hDEADBEEF);
        #1 res = 1'b1;
        #1 check("async_reset", dataOut, 32'h0);
        @(posedge clk);
        #2;
        drive(1'b1, 1'b1, 12'h010, 12'h010, 32'h5555AAAA);
        check("reset_hold", dataOut, 32'h0);
        res = 1'b0;
        drive(1'b1, 1'b0, 12'h010, 12'h000, 32'h0);
        check("write_dropped", dataOut, 32'hDEADBEEF);

        // Randomized traffic, concentrated on few addresses to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) res = 1'b1;
            else if (res) res = 1'b0;
            drive(1'($urandom), 1'($urandom), ra, wa, $urandom);
        end
        res = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 12'h000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
